// File: rtl/dfd_tn_pkg.sv
// Shared types and default constants for the trace-network sink.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package dfd_tn_pkg;

  // Flush sequencer states of the sink
  typedef enum logic [1:0] {
    SINK_IDLE  = 2'd0,
    SINK_FLUSH = 2'd1,
    SINK_DONE  = 2'd2
  } dfd_sink_state_e;

  localparam int SINK_DATA_BYTES   = 16;
  localparam int SINK_FIFO_DEPTH   = 8;
  localparam int SINK_BP_WATERMARK = 6;
  localparam int SINK_QUIET_CYCLES = 4;

  // Saturating increment for the 32-bit beat counters: sticks at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dfd_sink_fifo.sv
// Beat store for the trace sink: circular buffer of {src,data} entries.
// Latency: a pushed entry is visible at head_dat from the next cycle.
// Backpressure: none inside; caller only pushes when count<DEPTH and pops when count!=0.
//
// Ports: clk, reset_n (async active-low), push/push_dat (write), pop (advance head),
//        head_dat (oldest entry, combinational), count (occupancy, $clog2(DEPTH)+1 bits).
module dfd_sink_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 129
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // DEPTH is a power of two, so pointer overflow is exactly the modulo wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only pointers/count define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/dfd_trace_sink.sv
// Trace sink: buffers trace beats, drives per-source backpressure/flush and counts beats.
// Latency: one cycle from accepted beat to out_vld; out_* is a show-ahead head view.
// Backpressure: tr_gnt_out low when full; bp outputs high at/above watermark or sw_stop.
//
// Ports: clk, reset_n (async active-low); tr_vld_in/tr_src_in/tr_data_in/tr_gnt_out (ingress);
//        dst_/ntr_bp_out, dst_/ntr_flush_out (per-source control); sw_flush_req, sw_stop,
//        flush_done (software flush); out_vld/out_ready/out_src/out_data (egress);
//        dst_beat_cnt, ntr_beat_cnt (saturating accepted-beat counters).
module dfd_trace_sink
  import dfd_tn_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = SINK_DATA_BYTES,
  parameter int FIFO_DEPTH          = SINK_FIFO_DEPTH,
  parameter int BP_WATERMARK        = SINK_BP_WATERMARK,
  parameter int QUIET_CYCLES        = SINK_QUIET_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             tr_vld_in,
  input  logic                             tr_src_in,
  input  logic [DATA_WIDTH_IN_BYTES*8-1:0] tr_data_in,
  output logic                             tr_gnt_out,
  output logic                             dst_bp_out,
  output logic                             ntr_bp_out,
  output logic                             dst_flush_out,
  output logic                             ntr_flush_out,
  input  logic                             sw_flush_req,
  input  logic                             sw_stop,
  output logic                             flush_done,
  output logic                             out_vld,
  input  logic                             out_ready,
  output logic                             out_src,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0] out_data,
  output logic [31:0]                      dst_beat_cnt,
  output logic [31:0]                      ntr_beat_cnt
);

  localparam int DW = DATA_WIDTH_IN_BYTES * 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = $clog2(QUIET_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WMARK_C = CW'(BP_WATERMARK);
  localparam logic [QW-1:0] QUIET_C = QW'(QUIET_CYCLES);

  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [DW:0]     head_dat;

  dfd_sink_state_e state_q, state_d;
  logic [QW-1:0]   quiet_q, quiet_d;
  logic [31:0]     dst_cnt_q, dst_cnt_d;
  logic [31:0]     ntr_cnt_q, ntr_cnt_d;

  dfd_sink_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({tr_src_in, tr_data_in}),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  // Grant depends on registered occupancy only, so no comb path from tr_vld_in.
  // Being low when full also means push and pop never coincide at full.
  assign tr_gnt_out = (count < DEPTH_C);
  assign push       = tr_vld_in & tr_gnt_out;
  assign out_vld    = (count != '0);
  assign pop        = out_vld & out_ready;
  assign out_src    = head_dat[DW];
  assign out_data   = head_dat[DW-1:0];

  // Both sources are throttled together; a stop is signalled as bp+flush
  assign dst_bp_out    = (count >= WMARK_C) | sw_stop;
  assign ntr_bp_out    = dst_bp_out;
  assign dst_flush_out = (state_q == SINK_FLUSH) | sw_stop;
  assign ntr_flush_out = dst_flush_out;
  assign flush_done    = (state_q == SINK_DONE);

  // Flush ends after QUIET_CYCLES consecutive cycles with no offered beat and an
  // empty buffer; the check uses the updated count so the last quiet cycle is the
  // last FLUSH cycle. Requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    quiet_d = '0;
    unique case (state_q)
      SINK_IDLE: begin
        if (sw_flush_req) state_d = SINK_FLUSH;
      end
      SINK_FLUSH: begin
        quiet_d = (!tr_vld_in && (count == '0)) ? quiet_q + 1'b1 : '0;
        if (quiet_d == QUIET_C) state_d = SINK_DONE;
      end
      SINK_DONE: begin
        state_d = SINK_IDLE;
      end
      default: begin
        state_d = SINK_IDLE;
      end
    endcase
  end

  always_comb begin
    dst_cnt_d = dst_cnt_q;
    ntr_cnt_d = ntr_cnt_q;
    if (push) begin
      if (tr_src_in) ntr_cnt_d = sat_inc(ntr_cnt_q);
      else           dst_cnt_d = sat_inc(dst_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SINK_IDLE;
      quiet_q   <= '0;
      dst_cnt_q <= '0;
      ntr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      quiet_q   <= quiet_d;
      dst_cnt_q <= dst_cnt_d;
      ntr_cnt_q <= ntr_cnt_d;
    end
  end

  assign dst_beat_cnt = dst_cnt_q;
  assign ntr_beat_cnt = ntr_cnt_q;

endmodule

// File: tb/tb_dfd_trace_sink.sv
// Bench for dfd_trace_sink: directed vectors, data path checked by a scoreboard queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_dfd_trace_sink;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tr_vld_in;
  logic          tr_src_in;
  logic [DW-1:0] tr_data_in;
  logic          tr_gnt_out;
  logic          dst_bp_out;
  logic          ntr_bp_out;
  logic          dst_flush_out;
  logic          ntr_flush_out;
  logic          sw_flush_req;
  logic          sw_stop;
  logic          flush_done;
  logic          out_vld;
  logic          out_ready;
  logic          out_src;
  logic [DW-1:0] out_data;
  logic [31:0]   dst_beat_cnt;
  logic [31:0]   ntr_beat_cnt;

  always #5 clk = ~clk;

  dfd_trace_sink dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tr_vld_in     (tr_vld_in),
    .tr_src_in     (tr_src_in),
    .tr_data_in    (tr_data_in),
    .tr_gnt_out    (tr_gnt_out),
    .dst_bp_out    (dst_bp_out),
    .ntr_bp_out    (ntr_bp_out),
    .dst_flush_out (dst_flush_out),
    .ntr_flush_out (ntr_flush_out),
    .sw_flush_req  (sw_flush_req),
    .sw_stop       (sw_stop),
    .flush_done    (flush_done),
    .out_vld       (out_vld),
    .out_ready     (out_ready),
    .out_src       (out_src),
    .out_data      (out_data),
    .dst_beat_cnt  (dst_beat_cnt),
    .ntr_beat_cnt  (ntr_beat_cnt)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [DW:0] exp_q[$];
  logic [31:0] exp_dst;
  logic [31:0] exp_ntr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {32'(i), 32'hA5A5_0000 ^ 32'(i * 3), ~32'(i), 32'h1234_5678 + 32'(i)};
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    tr_vld_in    = 1'b0;
    tr_src_in    = 1'b0;
    tr_data_in   = '0;
    sw_flush_req = 1'b0;
  endtask

  // Offer one beat this cycle; 'accept' says whether the sink must take it
  task automatic offer(input logic s, input int i, input bit accept);
    tr_vld_in  = 1'b1;
    tr_src_in  = s;
    tr_data_in = pat(i);
    if (accept) begin
      exp_q.push_back({s, pat(i)});
      if (s) exp_ntr = sat(exp_ntr);
      else   exp_dst = sat(exp_dst);
    end
  endtask

  // Scoreboard monitor: every handshake on the output must match the oldest expected beat
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_vld === 1'b1 && out_ready === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: actual %0h required none", {out_src, out_data});
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({out_src, out_data} === e) n_pass++;
        else $display("FAIL sb_beat: actual %0h required %0h", {out_src, out_data}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] prev;
    reset_n   = 1'b0;
    out_ready = 1'b0;
    sw_stop   = 1'b0;
    idle_in();
    exp_dst = '0;
    exp_ntr = '0;

    // Reset values
    repeat (2) smp();
    chk("rst_gnt", 32'(tr_gnt_out), 32'd1);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_bp", {dst_bp_out, ntr_bp_out}, 32'd0);
    chk("rst_flush", {dst_flush_out, ntr_flush_out}, 32'd0);
    chk("rst_done", 32'(flush_done), 32'd0);
    chk("rst_dst_cnt", dst_beat_cnt, 32'd0);
    chk("rst_ntr_cnt", ntr_beat_cnt, 32'd0);
    cyc();
    reset_n = 1'b1;

    // Fill to full with the output stalled
    for (int i = 0; i < 8; i++) begin
      offer(i[0], i, 1'b1);
      smp();
      chk("fill_gnt", 32'(tr_gnt_out), 32'd1);
      chk("fill_bp", {dst_bp_out, ntr_bp_out}, (i >= 6) ? 32'd3 : 32'd0);
      chk("fill_out_vld", 32'(out_vld), (i != 0) ? 32'd1 : 32'd0);
      cyc();
    end
    idle_in();
    smp();
    chk("full_gnt", 32'(tr_gnt_out), 32'd0);
    chk("full_bp", {dst_bp_out, ntr_bp_out}, 32'd3);
    chk("full_out_vld", 32'(out_vld), 32'd1);
    chk("full_dst_cnt", dst_beat_cnt, exp_dst);
    chk("full_ntr_cnt", ntr_beat_cnt, exp_ntr);
    cyc();

    // Full: offered beat refused while one beat drains
    offer(1'b1, 100, 1'b0);
    out_ready = 1'b1;
    smp();
    chk("fullpop_gnt", 32'(tr_gnt_out), 32'd0);
    cyc();
    idle_in();
    out_ready = 1'b0;
    smp();
    chk("after_pop_gnt", 32'(tr_gnt_out), 32'd1);
    chk("after_pop_bp", {dst_bp_out, ntr_bp_out}, 32'd3);
    chk("after_pop_ntr_cnt", ntr_beat_cnt, exp_ntr);
    cyc();

    // Drain remaining 7 beats
    out_ready = 1'b1;
    repeat (7) cyc();
    out_ready = 1'b0;
    smp();
    chk("drain_out_vld", 32'(out_vld), 32'd0);
    chk("drain_sb_left", 32'(exp_q.size()), 32'd0);
    chk("drain_bp", {dst_bp_out, ntr_bp_out}, 32'd0);
    cyc();

    // Flush with nothing queued: 4 FLUSH cycles then one DONE
    sw_flush_req = 1'b1;
    smp();
    chk("f1_req_cycle", {dst_flush_out, ntr_flush_out}, 32'd0);
    cyc();
    sw_flush_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("f1_flush", {dst_flush_out, ntr_flush_out}, 32'd3);
      chk("f1_done_early", 32'(flush_done), 32'd0);
      cyc();
    end
    smp();
    chk("f1_done", 32'(flush_done), 32'd1);
    chk("f1_flush_off", {dst_flush_out, ntr_flush_out}, 32'd0);
    cyc();
    smp();
    chk("f1_idle_done", 32'(flush_done), 32'd0);
    cyc();

    // Flush with 3 beats queued, second request mid-flush ignored
    for (int i = 0; i < 3; i++) begin
      offer(i[0], 10 + i, 1'b1);
      cyc();
    end
    idle_in();
    sw_flush_req = 1'b1;
    smp();
    chk("f2_req_cycle", {dst_flush_out, ntr_flush_out}, 32'd0);
    cyc();
    sw_flush_req = 1'b0;
    smp();
    chk("f2_stalled_flush", {dst_flush_out, ntr_flush_out}, 32'd3);
    cyc();
    for (int c = 0; c < 8; c++) begin
      out_ready    = 1'b1;
      sw_flush_req = (c == 4);
      smp();
      chk("f2_flush", {dst_flush_out, ntr_flush_out}, (c < 7) ? 32'd3 : 32'd0);
      chk("f2_done", 32'(flush_done), (c == 7) ? 32'd1 : 32'd0);
      cyc();
    end
    sw_flush_req = 1'b0;
    out_ready    = 1'b0;
    smp();
    chk("f2_idle_flush", {dst_flush_out, ntr_flush_out}, 32'd0);
    chk("f2_idle_done", 32'(flush_done), 32'd0);
    chk("f2_dst_cnt", dst_beat_cnt, exp_dst);
    cyc();

    // Stop request
    sw_stop = 1'b1;
    smp();
    chk("stop_bp", {dst_bp_out, ntr_bp_out}, 32'd3);
    chk("stop_flush", {dst_flush_out, ntr_flush_out}, 32'd3);
    cyc();
    sw_stop = 1'b0;
    smp();
    chk("unstop_bp", {dst_bp_out, ntr_bp_out}, 32'd0);
    chk("unstop_flush", {dst_flush_out, ntr_flush_out}, 32'd0);
    cyc();

    // NTrace counter saturation from a preloaded value
    force dut.ntr_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.ntr_cnt_q;
    #1;
    exp_ntr = 32'hFFFF_FFFE;
    chk("sat_preload", ntr_beat_cnt, exp_ntr);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      prev = exp_ntr;
      offer(1'b1, 20 + k, 1'b1);
      smp();
      chk("sat_step", ntr_beat_cnt, prev);
      cyc();
    end
    idle_in();
    smp();
    chk("sat_ntr_cnt", ntr_beat_cnt, 32'hFFFF_FFFF);
    chk("sat_dst_cnt", dst_beat_cnt, exp_dst);
    cyc();
    out_ready = 1'b0;
    smp();
    chk("sat_sb_left", 32'(exp_q.size()), 32'd0);
    cyc();

    // Reset in the middle of a flush
    sw_flush_req = 1'b1;
    cyc();
    sw_flush_req = 1'b0;
    cyc();
    smp();
    chk("mid_flush_on", {dst_flush_out, ntr_flush_out}, 32'd3);
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_flush", {dst_flush_out, ntr_flush_out}, 32'd0);
    chk("arst_done", 32'(flush_done), 32'd0);
    chk("arst_gnt", 32'(tr_gnt_out), 32'd1);
    chk("arst_ntr_cnt", ntr_beat_cnt, 32'd0);
    chk("arst_dst_cnt", dst_beat_cnt, 32'd0);
    exp_dst = '0;
    exp_ntr = '0;
    exp_q.delete();
    repeat (2) begin
      smp();
      chk("arst_hold_done", 32'(flush_done), 32'd0);
    end
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("post_rst_done", 32'(flush_done), 32'd0);
      chk("post_rst_flush", {dst_flush_out, ntr_flush_out}, 32'd0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
